// File: rtl/deserializer.sv
// Gathers N_SAMPLES words from a valid/ready stream into one parallel frame.
// The next frame's first word can be captured on the same edge that the current frame leaves.
module deserializer #(
   parameter int BIT_WIDTH = 32,
   parameter int N_SAMPLES = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BIT_WIDTH-1:0] recv_msg,
   input  logic                 recv_val,
   output logic                 recv_rdy,
   output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES],
   output logic                 send_val,
   input  logic                 send_rdy
);

   localparam int CNT_W = $clog2(N_SAMPLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

   typedef enum logic {FILL, FULL} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_WIDTH-1:0] data_q [N_SAMPLES];
   logic [BIT_WIDTH-1:0] data_d [N_SAMPLES];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      case (state_q)
         FILL: begin
            if (recv_val) begin
               data_d[cnt_q] = recv_msg;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = FULL;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         FULL: begin
            // Frame departs; a concurrent input word becomes word 0 of the next frame.
            if (send_rdy) begin
               state_d = FILL;
               if (recv_val) begin
                  data_d[0] = recv_msg;
                  cnt_d     = CNT_W'(1);
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FILL;
         cnt_q   <= '0;
         data_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   assign recv_rdy = (state_q == FILL) || send_rdy;
   assign send_val = (state_q == FULL);
   assign send_msg = data_q;

endmodule

// File: doc/deserializer.md
# deserializer

Collects a stream of BIT_WIDTH-bit words, one per valid/ready handshake, into a frame of N_SAMPLES words. It presents the whole frame in parallel on a single valid/ready output. It is the inverse of the serializer stage and sits directly downstream of the SERDES serial link. It feeds parallel sample frames to the processing blocks. It sustains one word per cycle with no bubble between frames.

## Interface
- BIT_WIDTH, 32, width of each sample word
- N_SAMPLES, 8, words per frame; legal range 2..256

- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- recv_msg  input  BIT_WIDTH  incoming serial word
- recv_val  input  1  recv_msg valid
- recv_rdy  output  1  block can accept recv_msg this cycle
- send_msg  output  [N_SAMPLES-1:0] x BIT_WIDTH (unpacked array)  assembled frame; send_msg[i] is the i-th word received in the frame
- send_val  output  1  frame complete and held
- send_rdy  input  1  consumer accepts frame this cycle

## Operation
- Storage: N_SAMPLES registers of BIT_WIDTH, plus a word counter cnt of width $clog2(N_SAMPLES) and a 1-bit state.
- send_msg[i] is driven directly from register i, with no mux and no combinational path from recv_msg.
- FILL state:
  - recv_rdy=1, send_val=0.
  - When recv_val=1, reg[cnt] <= recv_msg.
  - If cnt==N_SAMPLES-1: cnt <= 0 and state <= FULL. Otherwise cnt <= cnt+1.
  - When recv_val=0, nothing changes.
- FULL state:
  - send_val=1, and recv_rdy=send_rdy (combinational pass-through).
  - send_rdy=0: registers, cnt and state hold. send_msg stays stable while send_val=1 and send_rdy=0. Any recv_val is ignored and the word is not consumed.
  - send_rdy=1, recv_val=0: state <= FILL, cnt stays 0.
  - send_rdy=1, recv_val=1: the frame leaves and reg[0] <= recv_msg in the same edge. Then cnt <= 1 and state <= FILL. Word 0 of the next frame is captured without a bubble.
- Registers not being written keep their old contents. A partly filled frame shows stale words in the higher slots, but send_val=0 in that case.
- Counter arithmetic is unsigned. cnt never exceeds N_SAMPLES-1 and never wraps except through the FILL→FULL transition.

## Timing
- Reset (synchronous, active-high):
  - state=FILL, cnt=0, all data registers=0.
  - Outputs the cycle after reset: recv_rdy=1, send_val=0, send_msg all zero.
  - Reset overrides every handshake in the same cycle.
  - Reset in the middle of a frame discards the partial frame. Reset during FULL drops the frame even if send_rdy=1 in that cycle.
- Latency: the N_SAMPLES-th accepted word appears in send_msg[N_SAMPLES-1] and send_val rises on the next posedge, i.e. one cycle.
- Throughput: one word per cycle when recv_val is held high and send_rdy=1 whenever send_val=1. A frame of N words occupies exactly N cycles.
- send_val has no combinational dependency on any input.
- recv_rdy depends combinationally on send_rdy only in FULL.
- Simultaneous recv_val and send_rdy in FULL count as two independent transfers on one edge, as described under Operation.

## Test plan
- Reset, then check outputs: after reset, recv_rdy=1, send_val=0, send_msg all 0x00000000.
- Basic frame (BIT_WIDTH=32, N_SAMPLES=8): send words 0x10..0x17 back-to-back with send_rdy=0. send_val rises one cycle after 0x17 is accepted, send_msg[0..7]=0x10..0x17. recv_rdy=0 while the frame is held.
- Backpressure hold: keep send_rdy=0 for 5 cycles with recv_val=1 and recv_msg=0xDEAD. The frame is unchanged and no word is consumed. Raising send_rdy completes the handshake, and 0xDEAD is taken as word 0 of the next frame in that same cycle.
- Continuous streaming: 24 words 0..23 with recv_val=1 and send_rdy=1 throughout. Three frames {0..7}, {8..15}, {16..23} arrive 8 cycles apart. recv_rdy never drops.
- Gapped input: words 0xA0..0xA7 with recv_val toggled on and off. Only accepted words advance cnt, and the frame equals 0xA0..0xA7 in order.
- Reset mid-frame: accept 3 words, assert reset for one cycle, then send 0xB0..0xB7. The frame is exactly 0xB0..0xB7, with no leftover words from before the reset.
